// File: rtl/ram_nx8_ws_pkg.sv
// Shared encodings for the byte-addressable wait-state RAM.
package ram_nx8_ws_pkg;

    // Access size encodings on MS[1:0]
    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;

    // Transfer direction on ReadWrite
    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    // Handshake FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Number of bytes touched by an access size; reserved size counts as one
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            MS_HALF: size_bytes = 3'd2;
            MS_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ram_nx8_ws_array.sv
// DEPTH x 8 byte storage: 4-lane byte-enabled write, combinational 4-byte read.
module ram_nx8_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] memory [DEPTH];

    // Lane i writes the byte at addr+i
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                memory[AW'(addr + AW'(i))] <= wdata[8*i +: 8];
            end
        end
    end

    // Lane i presents the byte at addr+i; lanes past the access are ignored upstream
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = memory[AW'(addr + AW'(i))];
        end
    end

endmodule

// File: rtl/ram_nx8_ws.sv
// Parametrised byte RAM with MOV/MOC 4-phase handshake and programmable wait states.
module ram_nx8_ws
    import ram_nx8_ws_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned BIG_ENDIAN  = 1,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              ReadWrite,
    input  logic [2:0]        MS,
    input  logic [31:0]       DataIn,
    input  logic [ADDR_W-1:0] Address,
    output logic              MOC,
    output logic [31:0]       DataOut,
    output logic              MemErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = ADDR_W + 1;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   lat_addr;
    logic [1:0]      lat_size;
    logic            lat_sext;
    logic            lat_rw;
    logic [31:0]     lat_data;
    logic            lat_err;

    logic [2:0]      req_nbytes_c;
    logic [EW-1:0]   req_last_c;
    logic            req_err_c;
    logic            commit_c;
    logic            arr_we_c;
    logic [3:0]      wr_be_c;
    logic [31:0]     wr_lanes_c;
    logic [31:0]     rd_lanes_c;
    logic [31:0]     rd_val_c;
    logic [15:0]     rd_half_c;

    // Request error check on the live inputs, evaluated at acceptance
    always_comb begin
        req_nbytes_c = size_bytes(MS[1:0]);
        req_last_c   = EW'(Address) + EW'(req_nbytes_c) - EW'(1);
        req_err_c    = (MS[1:0] == 2'b11) || (req_last_c >= EW'(DEPTH));
        if (ALIGN_CHECK != 0) begin
            if ((MS[1:0] == MS_HALF && Address[0]) ||
                (MS[1:0] == MS_WORD && Address[1:0] != 2'b00)) begin
                req_err_c = 1'b1;
            end
        end
    end

    // The access happens on the edge that leaves WAIT
    assign commit_c = (state == S_WAIT) && (cnt == 4'd0);
    assign arr_we_c = commit_c && (lat_rw == DIR_WRITE) && !lat_err;

    // Steer the right-justified write data onto byte lanes addr+0..addr+3
    always_comb begin
        wr_be_c    = 4'b0000;
        wr_lanes_c = '0;
        case (lat_size)
            MS_BYTE: begin
                wr_be_c          = 4'b0001;
                wr_lanes_c[7:0]  = lat_data[7:0];
            end
            MS_HALF: begin
                wr_be_c          = 4'b0011;
                wr_lanes_c[15:0] = (BIG_ENDIAN != 0) ? {lat_data[7:0], lat_data[15:8]}
                                                     : lat_data[15:0];
            end
            MS_WORD: begin
                wr_be_c    = 4'b1111;
                wr_lanes_c = (BIG_ENDIAN != 0)
                    ? {lat_data[7:0], lat_data[15:8], lat_data[23:16], lat_data[31:24]}
                    : lat_data;
            end
            default: begin
                wr_be_c    = 4'b0000;
            end
        endcase
    end

    // Reassemble the read bytes and extend to 32 bits
    always_comb begin
        rd_half_c = (BIG_ENDIAN != 0) ? {rd_lanes_c[7:0], rd_lanes_c[15:8]}
                                      : rd_lanes_c[15:0];
        case (lat_size)
            MS_BYTE: rd_val_c = {{24{lat_sext & rd_lanes_c[7]}}, rd_lanes_c[7:0]};
            MS_HALF: rd_val_c = {{16{lat_sext & rd_half_c[15]}}, rd_half_c};
            default: rd_val_c = (BIG_ENDIAN != 0)
                ? {rd_lanes_c[7:0], rd_lanes_c[15:8], rd_lanes_c[23:16], rd_lanes_c[31:24]}
                : rd_lanes_c;
        endcase
    end

    ram_nx8_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK   (CLK),
        .we    (arr_we_c),
        .be    (wr_be_c),
        .addr  (lat_addr),
        .wdata (wr_lanes_c),
        .rdata (rd_lanes_c)
    );

    // Handshake FSM, wait counter, request latch and registered outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            MOC     <= 1'b0;
            DataOut <= '0;
            MemErr  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MOV) begin
                        lat_addr <= Address[AW-1:0];
                        lat_size <= MS[1:0];
                        lat_sext <= MS[2];
                        lat_rw   <= ReadWrite;
                        lat_data <= DataIn;
                        lat_err  <= req_err_c;
                        cnt      <= 4'(WAIT_STATES);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= S_DONE;
                        MOC    <= 1'b1;
                        MemErr <= lat_err;
                        if (lat_rw == DIR_READ && !lat_err) begin
                            DataOut <= rd_val_c;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!MOV) begin
                        state  <= S_IDLE;
                        MOC    <= 1'b0;
                        MemErr <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
